// File: rtl/i3c_bus_input_conditioner.sv
// I3C SCL/SDA input conditioning: pad synchronizers, per-line glitch filters,
// edge/START/STOP pulse generation, bus-busy tracking and bus-free timeout.
module i3c_bus_input_conditioner #(
  parameter int SyncStages     = 2,
  parameter int FilterCntWidth = 4,
  parameter int IdleCntWidth   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      scl_raw_i,
  input  logic                      sda_raw_i,
  input  logic                      enable_i,
  input  logic [FilterCntWidth-1:0] filter_cycles_i,
  input  logic [IdleCntWidth-1:0]   idle_thresh_i,
  output logic                      scl_o,
  output logic                      sda_o,
  output logic                      scl_rise_o,
  output logic                      scl_fall_o,
  output logic                      start_det_o,
  output logic                      stop_det_o,
  output logic                      bus_busy_o,
  output logic                      bus_idle_o
);

  localparam logic [FilterCntWidth-1:0] FiltOne = {{(FilterCntWidth-1){1'b0}}, 1'b1};
  localparam logic [IdleCntWidth-1:0]   IdleOne = {{(IdleCntWidth-1){1'b0}}, 1'b1};

  logic [SyncStages-1:0]     scl_sync_q, scl_sync_d;
  logic [SyncStages-1:0]     sda_sync_q, sda_sync_d;
  logic                      scl_syn, sda_syn;
  logic                      scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic [FilterCntWidth-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic                      scl_prev_q, sda_prev_q;
  logic                      scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
  logic                      start_q, start_d, stop_q, stop_d;
  logic                      busy_q, busy_d;
  logic                      idle_q, idle_d;
  logic [IdleCntWidth-1:0]   idle_cnt_q, idle_cnt_d;
  logic                      start_c, stop_c, idle_cond;

  always_comb begin
    scl_sync_d = {scl_sync_q[SyncStages-2:0], scl_raw_i};
    sda_sync_d = {sda_sync_q[SyncStages-2:0], sda_raw_i};
    scl_syn    = scl_sync_q[SyncStages-1];
    sda_syn    = sda_sync_q[SyncStages-1];

    // A pending change commits once it has persisted past filter_cycles_i
    scl_f_d   = scl_f_q;
    scl_cnt_d = '0;
    if (scl_syn != scl_f_q) begin
      if (scl_cnt_q >= filter_cycles_i) scl_f_d = scl_syn;
      else scl_cnt_d = scl_cnt_q + FiltOne;
    end

    sda_f_d   = sda_f_q;
    sda_cnt_d = '0;
    if (sda_syn != sda_f_q) begin
      if (sda_cnt_q >= filter_cycles_i) sda_f_d = sda_syn;
      else sda_cnt_d = sda_cnt_q + FiltOne;
    end

    scl_rise_d = scl_f_q & ~scl_prev_q;
    scl_fall_d = ~scl_f_q & scl_prev_q;

    // SCL must be high on both sides of the SDA change, so a simultaneous
    // SCL transition never qualifies as START or STOP
    start_c = enable_i & scl_prev_q & scl_f_q & sda_prev_q & ~sda_f_q;
    stop_c  = enable_i & scl_prev_q & scl_f_q & ~sda_prev_q & sda_f_q;
    start_d = start_c;
    stop_d  = stop_c;

    busy_d = busy_q;
    if (!enable_i)    busy_d = 1'b0;
    else if (start_c) busy_d = 1'b1;
    else if (stop_c)  busy_d = 1'b0;

    idle_cond  = enable_i & scl_f_q & sda_f_q & ~busy_q;
    idle_cnt_d = '0;
    if (idle_cond) idle_cnt_d = (&idle_cnt_q) ? idle_cnt_q : idle_cnt_q + IdleOne;
    idle_d = idle_cond & (idle_cnt_q >= idle_thresh_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      idle_q     <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
      idle_q     <= idle_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign scl_o       = scl_f_q;
  assign sda_o       = sda_f_q;
  assign scl_rise_o  = scl_rise_q;
  assign scl_fall_o  = scl_fall_q;
  assign start_det_o = start_q;
  assign stop_det_o  = stop_q;
  assign bus_busy_o  = busy_q;
  assign bus_idle_o  = idle_q;

endmodule
